// File: rtl/skid_buffer_if.sv
// skid_buffer_if: upstream/downstream ready-valid bundle for skid_buffer.
interface skid_buffer_if #(parameter int N = 32);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic [1:0]   occupancy;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry ready/valid stage; in_ready is registered so out_ready never reaches it combinationally.
module skid_buffer #(
  parameter int           N     = 32,
  parameter logic [N-1:0] RESET = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  skid_buffer_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t       r_state;
  logic [N-1:0] r_main;
  logic [N-1:0] r_skid;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [1:0]   r_occ;
  logic         w_in_fire;
  logic         w_out_fire;
  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main;
  assign bus.occupancy = r_occ;
  // Handshake flags and occupancy are registered alongside the state so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state     <= EMPTY;
      r_main      <= RESET;
      r_skid      <= RESET;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      case (r_state)
        EMPTY: if (w_in_fire) begin
          r_state     <= BUSY;
          r_main      <= bus.in_data;
          r_out_valid <= 1'b1;
          r_occ       <= 2'd1;
        end
        BUSY: if (w_in_fire && w_out_fire) begin
          r_main <= bus.in_data;
        end else if (w_in_fire) begin
          r_state    <= FULL;
          r_skid     <= bus.in_data;
          r_in_ready <= 1'b0;
          r_occ      <= 2'd2;
        end else if (w_out_fire) begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
          r_occ       <= 2'd0;
        end
        FULL: if (w_out_fire) begin
          r_state    <= BUSY;
          r_main     <= r_skid;
          r_in_ready <= 1'b1;
          r_occ      <= 2'd1;
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_occ       <= 2'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: directed and random ready/valid traffic checked against a queue model.
module tb_skid_buffer;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  skid_buffer_if #(.N(N)) bus();
  skid_buffer #(.N(N), .RESET('0)) dut (.clk(clk), .rst(rst), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic [N-1:0] q[$];
  logic [N-1:0] last = '0;
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic c, input logic v, input logic [N-1:0] d, input logic o);
    bit fi, fo;
    rst = r; clr = c; bus.in_valid = v; bus.in_data = d; bus.out_ready = o;
    fi = v && q.size() < 2;
    fo = q.size() > 0 && o;
    @(posedge clk);
    if (r || c) begin
      q.delete();
      last = '0;
    end else begin
      if (fo) void'(q.pop_front());
      if (fi) q.push_back(d);
      if (q.size() > 0) last = q[0];
    end
    #1;
    chk("occupancy", N'(bus.occupancy), N'(q.size()));
    chk("in_ready", N'(bus.in_ready), N'(q.size() < 2));
    chk("out_valid", N'(bus.out_valid), N'(q.size() > 0));
    chk("out_data", bus.out_data, last);
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    cyc(1, 0, 1, 32'hDEAD_BEEF, 0);
    cyc(1, 0, 1, 32'hDEAD_BEEF, 0);
    cyc(0, 0, 0, 32'hDEAD_BEEF, 0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_in_ready", N'(bus.in_ready), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 1, N'(k), 1);
      chk("stream_data", bus.out_data, N'(k));
      chk("stream_occ", N'(bus.occupancy), 32'h1);
    end
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 1, 32'hA, 0);
    cyc(0, 0, 1, 32'hB, 0);
    chk("bp_occ_full", N'(bus.occupancy), 32'h2);
    chk("bp_in_ready_low", N'(bus.in_ready), 32'h0);
    cyc(0, 0, 1, 32'hC, 0);
    chk("bp_hold_a", bus.out_data, 32'hA);
    cyc(0, 0, 1, 32'hC, 1);
    chk("bp_out_b", bus.out_data, 32'hB);
    cyc(0, 0, 1, 32'hC, 1);
    chk("bp_out_c", bus.out_data, 32'hC);
    cyc(0, 0, 0, '0, 1);
    chk("bp_drained", N'(bus.occupancy), 32'h0);
    cyc(0, 0, 1, 32'h10, 0);
    cyc(0, 0, 1, 32'h11, 1);
    chk("simul_data", bus.out_data, 32'h11);
    chk("simul_occ", N'(bus.occupancy), 32'h1);
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 1, 32'h5, 0);
    cyc(0, 0, 1, 32'h6, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, $urandom, 0);
      chk("stall_data", bus.out_data, 32'h5);
      chk("stall_valid", N'(bus.out_valid), 32'h1);
    end
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 1, 32'h7, 0);
    cyc(0, 0, 1, 32'h8, 0);
    cyc(0, 1, 1, 32'h9, 0);
    chk("clr_occ", N'(bus.occupancy), 32'h0);
    chk("clr_valid", N'(bus.out_valid), 32'h0);
    cyc(0, 0, 1, 32'h12, 0);
    cyc(1, 1, 1, 32'h13, 1);
    chk("rstclr_occ", N'(bus.occupancy), 32'h0);
    chk("rstclr_data", bus.out_data, 32'h0);
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, 1'($urandom), $urandom,
          $urandom_range(0, 3) != 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
